counter_5: RTL and testbench

COUNTER_5 -- requirements
Module: counter_5

---
 rtl/counter_5.sv | 51 +++++
 tb/tb_counter_5.sv | 132 +++++++++++++
 2 files changed

// File: rtl/counter_5.sv
// Five-bit synchronous up-counter built from toggle flip-flops and an AND carry chain.
// count clears asynchronously on clr and wraps from 31 back to 0.
module counter_5_bit (
    input  logic i_clock,
    input  logic i_clr,
    input  logic i_en,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clock or posedge i_clr) begin
        if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= ~r_q;
        end
    end

    assign o_q = r_q;

endmodule

module counter_5 (
    output logic [4:0] count,
    input  logic       clr,
    input  logic       clock
);

    // w_carry[i] is high when every lower bit is 1, so bit i toggles on this edge.
    logic [4:0] w_carry;

    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < 5; gi++) begin : g_carry
            assign w_carry[gi] = w_carry[gi-1] & count[gi-1];
        end

        for (gi = 0; gi < 5; gi++) begin : g_bit
            counter_5_bit u_bit (
                .i_clock (clock),
                .i_clr   (clr),
                .i_en    (w_carry[gi]),
                .o_q     (count[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_counter_5.sv
// Testbench for counter_5: directed reset, sequence, wrap and clear checks followed by
// randomized clr pulses, all compared against an integer modulo-32 reference count.
module tb_counter_5;

    logic       clock;
    logic       clr;
    logic [4:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int modelCount  = 0;

    counter_5 dut (
        .count (count),
        .clr   (clr),
        .clock (clock)
    );

    // 40 ns period with the first rising edge at 20 ns.
    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    // Reference model: plain modulo-32 arithmetic on every rising edge outside of clear.
    always @(posedge clock) begin
        if (!clr) begin
            modelCount = (modelCount + 1) % 32;
        end
    end

    task automatic checkOutput(input string tag, input int expected);
        logic [4:0] exp5;
        exp5 = expected[4:0];
        vectors++;
        assert (count === exp5) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, count, exp5);
        end
    endtask

    // Waits for the falling edge (midway between rising edges), then a further delay, then drives clr.
    task automatic applyStimulus(input logic clrValue, input int delayNs);
        @(negedge clock);
        if (delayNs > 0) #(delayNs);
        clr = clrValue;
        if (clrValue) modelCount = 0;
    endtask

    initial begin
        int guard;
        clr = 1'b1;
        modelCount = 0;

        #1;
        checkOutput("reset_immediate", 0);
        @(posedge clock); #1;
        checkOutput("reset_hold_20ns", 0);
        @(posedge clock); #1;
        checkOutput("reset_hold_60ns", 0);

        // Release at 80 ns and sample every 40 ns starting at 80 ns.
        applyStimulus(1'b0, 0);
        checkOutput("seq_0", 0);
        for (int i = 1; i < 40; i++) begin
            @(negedge clock);
            checkOutput($sformatf("seq_%0d", i), i % 32);
        end

        // Carry chain into bit 3 and bit 4.
        guard = 0;
        while (modelCount != 7 && guard < 40) begin @(negedge clock); guard++; end
        checkOutput("carry_7", 7);
        @(negedge clock); checkOutput("carry_8", 8);
        guard = 0;
        while (modelCount != 15 && guard < 40) begin @(negedge clock); guard++; end
        checkOutput("carry_15", 15);
        @(negedge clock); checkOutput("carry_16", 16);

        // Wrap from 31 to 0 and continue.
        guard = 0;
        while (modelCount != 31 && guard < 40) begin @(negedge clock); guard++; end
        checkOutput("wrap_31", 31);
        @(negedge clock); checkOutput("wrap_0", 0);
        @(negedge clock); checkOutput("wrap_1", 1);

        // Asynchronous clear midway between edges at count 13.
        guard = 0;
        while (modelCount != 12 && guard < 40) begin @(negedge clock); guard++; end
        @(negedge clock);
        checkOutput("pre_clr_13", 13);
        clr = 1'b1;
        modelCount = 0;
        #1;
        checkOutput("async_clr_13", 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("clr_held_%0d", i), 0);
        end
        applyStimulus(1'b0, 0);
        @(posedge clock); #1;
        checkOutput("clr_release_1", 1);

        // Asynchronous clear while count is 31.
        guard = 0;
        while (modelCount != 31 && guard < 40) begin @(negedge clock); guard++; end
        checkOutput("pre_clr_31", 31);
        applyStimulus(1'b1, 7);
        #1;
        checkOutput("async_clr_31", 0);
        applyStimulus(1'b0, 0);

        // Randomized clr pulses at random points between edges.
        for (int i = 0; i < 300; i++) begin
            if (!clr && $urandom_range(0, 11) == 0) begin
                applyStimulus(1'b1, $urandom_range(1, 15));
                #1;
                checkOutput($sformatf("rand_clr_%0d", i), modelCount);
            end else if (clr && $urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, 0);
                checkOutput($sformatf("rand_rel_%0d", i), modelCount);
            end else begin
                @(negedge clock);
                checkOutput($sformatf("rand_%0d", i), modelCount);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
